// File: rtl/cache_miss_ctrl.sv
// Miss handler for a 4-way set-associative cache.
// On an accepted miss it chooses a victim way (first invalid way, otherwise
// the LRU way), writes the victim line back when it is dirty, fetches the new
// line from memory beat by beat into the data array, commits the tag, and
// pulses the LRU update with the victim way.
//
// Ports
//   clk, rst                      clock (rising edge), async active-low reset
//   miss_*                        miss request (valid/ready, tag, set)
//   way_valid_i/way_dirty_i/way_tags_i, lru_way_i   state of the addressed set
//   mem_cmd_*                     memory command channel (writeback or fill)
//   mem_wdata_*, arr_*            writeback beats read from the data array
//   mem_rdata_*                   fill beats from memory
//   fill_*                        data-array beat write port
//   tag_we_o, tag_o               tag commit (valid = 1, dirty = 0)
//   lru_update_o, lru_index_o     MRU update towards the LRU list
//   done_o                        refill-complete pulse
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | ready for a miss
// WB_CMD    | issuing writeback command for the dirty victim
// WB_DATA   | streaming victim beats from the array to memory
// FILL_CMD  | issuing fill read command for the missing line
// FILL_DATA | writing fill beats into the data array
// DONE      | one-cycle tag commit, LRU update and done pulse
module cache_miss_ctrl #(
  parameter int TAG_W  = 20,
  parameter int SET_W  = 6,
  parameter int DATA_W = 32,
  parameter int BEATS  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      miss_v_i,
  output logic                      miss_ready_o,
  input  logic [TAG_W-1:0]          miss_tag_i,
  input  logic [SET_W-1:0]          miss_set_i,
  input  logic [3:0]                way_valid_i,
  input  logic [3:0]                way_dirty_i,
  input  logic [4*TAG_W-1:0]        way_tags_i,
  input  logic [1:0]                lru_way_i,
  output logic                      mem_cmd_v_o,
  input  logic                      mem_cmd_ready_i,
  output logic                      mem_cmd_we_o,
  output logic [TAG_W+SET_W-1:0]    mem_cmd_addr_o,
  output logic                      mem_wdata_v_o,
  input  logic                      mem_wdata_ready_i,
  output logic [DATA_W-1:0]         mem_wdata_o,
  output logic [$clog2(BEATS)-1:0]  arr_rd_beat_o,
  input  logic [DATA_W-1:0]         arr_rdata_i,
  input  logic                      mem_rdata_v_i,
  output logic                      mem_rdata_ready_o,
  input  logic [DATA_W-1:0]         mem_rdata_i,
  output logic                      fill_we_o,
  output logic [1:0]                fill_way_o,
  output logic [SET_W-1:0]          fill_set_o,
  output logic [$clog2(BEATS)-1:0]  fill_beat_o,
  output logic [DATA_W-1:0]         fill_data_o,
  output logic                      tag_we_o,
  output logic [TAG_W-1:0]          tag_o,
  output logic                      lru_update_o,
  output logic [1:0]                lru_index_o,
  output logic                      done_o
);

  localparam int BEAT_W = $clog2(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WB_CMD, S_WB_DATA, S_FILL_CMD, S_FILL_DATA, S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [BEAT_W-1:0]  beat, beat_nxt;
  logic [TAG_W-1:0]   tag_q, vtag_q;
  logic [SET_W-1:0]   set_q;
  logic [1:0]         way_q;
  logic [1:0]         victim;
  logic               victim_dirty;
  logic               accept;

  // Lowest-indexed invalid way wins; scanning downwards lets the lowest
  // index overwrite higher ones. All valid falls back to the LRU way.
  always_comb begin
    victim = lru_way_i;
    for (int w = 3; w >= 0; w--) begin
      if (!way_valid_i[w]) victim = 2'(w);
    end
  end

  assign victim_dirty = way_valid_i[victim] & way_dirty_i[victim];
  assign accept       = (state == S_IDLE) && miss_v_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      beat  <= '0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q  <= '0;
      vtag_q <= '0;
      set_q  <= '0;
      way_q  <= '0;
    end else if (accept) begin
      tag_q  <= miss_tag_i;
      set_q  <= miss_set_i;
      way_q  <= victim;
      vtag_q <= way_tags_i[victim*TAG_W +: TAG_W];
    end
  end

  assign fill_way_o = way_q;
  assign fill_set_o = set_q;
  assign tag_o      = tag_q;

  always_comb begin
    state_nxt         = state;
    beat_nxt          = beat;
    miss_ready_o      = 1'b0;
    mem_cmd_v_o       = 1'b0;
    mem_cmd_we_o      = 1'b0;
    mem_cmd_addr_o    = '0;
    mem_wdata_v_o     = 1'b0;
    mem_wdata_o       = '0;
    arr_rd_beat_o     = '0;
    mem_rdata_ready_o = 1'b0;
    fill_we_o         = 1'b0;
    fill_beat_o       = '0;
    fill_data_o       = '0;
    tag_we_o          = 1'b0;
    lru_update_o      = 1'b0;
    lru_index_o       = '0;
    done_o            = 1'b0;
    case (state)
      S_IDLE: begin
        miss_ready_o = 1'b1;
        if (miss_v_i) state_nxt = victim_dirty ? S_WB_CMD : S_FILL_CMD;
      end
      S_WB_CMD: begin
        mem_cmd_v_o    = 1'b1;
        mem_cmd_we_o   = 1'b1;
        mem_cmd_addr_o = {vtag_q, set_q};
        if (mem_cmd_ready_i) begin
          state_nxt = S_WB_DATA;
          beat_nxt  = '0;
        end
      end
      S_WB_DATA: begin
        mem_wdata_v_o = 1'b1;
        arr_rd_beat_o = beat;
        mem_wdata_o   = arr_rdata_i;
        if (mem_wdata_ready_i) begin
          beat_nxt = beat + 1'b1;
          if (beat == LAST_BEAT) begin
            state_nxt = S_FILL_CMD;
            beat_nxt  = '0;
          end
        end
      end
      S_FILL_CMD: begin
        mem_cmd_v_o    = 1'b1;
        mem_cmd_addr_o = {tag_q, set_q};
        if (mem_cmd_ready_i) state_nxt = S_FILL_DATA;
      end
      S_FILL_DATA: begin
        mem_rdata_ready_o = 1'b1;
        fill_we_o         = mem_rdata_v_i;
        fill_data_o       = mem_rdata_i;
        fill_beat_o       = beat;
        if (mem_rdata_v_i) begin
          beat_nxt = beat + 1'b1;
          if (beat == LAST_BEAT) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        tag_we_o     = 1'b1;
        lru_update_o = 1'b1;
        lru_index_o  = way_q;
        done_o       = 1'b1;
        state_nxt    = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
